// File: rtl/vlsu_load_meta_sched.sv
// vlsu_load_meta_sched: VLSU load front-end; allocates request IDs, computes commit count, forks meta to seq/shuffle stages.
// meta_o = {req_id, mode, sew, vd, vstart, vm, cmt_cnt}; define VLSU_SCHED_PERF_EN to add issue/stall counters.
module vlsu_load_meta_sched #(
  parameter int NrExits = 4,
  parameter int DLEN = 256,
  parameter int MaxReqs = 8,
  parameter int VlBits = 16,
  localparam int ReqIdBits = $clog2(MaxReqs),
  localparam int MetaBits = ReqIdBits + 2 * VlBits + 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [VlBits-1:0]    req_vl_i,
  input  logic [VlBits-1:0]    req_vstart_i,
  input  logic [1:0]           req_sew_i,
  input  logic [5:0]           req_vd_i,
  input  logic                 req_vm_i,
  input  logic [2:0]           req_mode_i,
  output logic                 seq_meta_valid_o,
  input  logic                 seq_meta_ready_i,
  output logic                 shf_meta_valid_o,
  input  logic                 shf_meta_ready_i,
  output logic [MetaBits-1:0]  meta_o,
  input  logic [MaxReqs-1:0]   vinsn_done_i,
  output logic                 done_valid_o,
  output logic [ReqIdBits-1:0] done_id_o,
  output logic [MaxReqs-1:0]   busy_o,
  output logic                 err_o
`ifdef VLSU_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_issued_o,
  output logic [31:0]          perf_stall_o
`endif
);
  localparam int CmtSh = $clog2(NrExits * DLEN / 8);
  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_e;
  state_e state;
  logic [MaxReqs-1:0] busy, alloc_mask, ret_mask, zl_mask;
  logic [ReqIdBits-1:0] id_q, free_id, ret_id;
  logic [VlBits-1:0] vl_q, vstart_q, cmt_q, cmt_nxt;
  logic [2:0] mode_q;
  logic [1:0] sew_q;
  logic [5:0] vd_q;
  logic vm_q, accept, ret_ok, zero_len, zl_done, issue_done;
  logic [VlBits+2:0] bytes, beats;
  assign busy_o = busy;
  assign req_ready_o = state == IDLE && !(&busy);
  assign accept = req_valid_i && req_ready_o;
  assign meta_o = {id_q, mode_q, sew_q, vd_q, vstart_q, vm_q, cmt_q};
  assign bytes = {3'b000, vl_q - vstart_q} << sew_q;
  assign beats = (bytes >> CmtSh) + (VlBits+3)'(|bytes[CmtSh-1:0]);
  assign cmt_nxt = VlBits'(beats - (VlBits+3)'(1));
  assign zero_len = vl_q <= vstart_q;
  assign ret_ok = $onehot(vinsn_done_i) && |(vinsn_done_i & busy);
  assign ret_mask = ret_ok ? vinsn_done_i : '0;
  // a retirement response takes the done port; a zero-length completion waits a cycle in CALC
  assign zl_done = state == CALC && zero_len && !ret_ok;
  assign zl_mask = MaxReqs'(zl_done) << id_q;
  assign alloc_mask = MaxReqs'(accept) << free_id;
  assign issue_done = state == ISSUE && (!seq_meta_valid_o || seq_meta_ready_i) && (!shf_meta_valid_o || shf_meta_ready_i);
  always_comb begin
    free_id = '0;
    ret_id = '0;
    for (int i = MaxReqs - 1; i >= 0; i--) begin
      if (!busy[i]) free_id = ReqIdBits'(i);
      if (vinsn_done_i[i]) ret_id = ReqIdBits'(i);
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      busy <= '0;
      id_q <= '0;
      vl_q <= '0;
      vstart_q <= '0;
      cmt_q <= '0;
      mode_q <= '0;
      sew_q <= '0;
      vd_q <= '0;
      vm_q <= 1'b0;
      seq_meta_valid_o <= 1'b0;
      shf_meta_valid_o <= 1'b0;
      done_valid_o <= 1'b0;
      done_id_o <= '0;
      err_o <= 1'b0;
    end else begin
      busy <= (busy & ~ret_mask & ~zl_mask) | alloc_mask;
      err_o <= err_o | ((|vinsn_done_i) & !ret_ok);
      done_valid_o <= ret_ok || zl_done;
      done_id_o <= ret_ok ? ret_id : id_q;
      if (accept) begin
        id_q <= free_id;
        vl_q <= req_vl_i;
        vstart_q <= req_vstart_i;
        sew_q <= req_sew_i;
        vd_q <= req_vd_i;
        vm_q <= req_vm_i;
        mode_q <= req_mode_i;
        state <= CALC;
      end
      if (state == CALC) begin
        cmt_q <= cmt_nxt;
        if (!zero_len) begin
          state <= ISSUE;
          seq_meta_valid_o <= 1'b1;
          shf_meta_valid_o <= 1'b1;
        end else if (zl_done) begin
          state <= IDLE;
        end
      end
      if (state == ISSUE) begin
        seq_meta_valid_o <= seq_meta_valid_o && !seq_meta_ready_i;
        shf_meta_valid_o <= shf_meta_valid_o && !shf_meta_ready_i;
        if (issue_done) state <= IDLE;
      end
    end
  end
`ifdef VLSU_SCHED_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_issued_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (issue_done && !(&perf_issued_o)) perf_issued_o <= perf_issued_o + 32'd1;
      if (req_valid_i && !req_ready_o && !(&perf_stall_o)) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vlsu_load_meta_sched.sv
// tb_vlsu_load_meta_sched: directed and randomized checks of vlsu_load_meta_sched against a pool/commit-count model.
module tb_vlsu_load_meta_sched;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o;
  logic [15:0] req_vl_i = '0, req_vstart_i = '0;
  logic [1:0] req_sew_i = '0;
  logic [5:0] req_vd_i = '0;
  logic req_vm_i = 1'b0;
  logic [2:0] req_mode_i = '0;
  logic seq_meta_valid_o, shf_meta_valid_o;
  logic seq_meta_ready_i = 1'b0, shf_meta_ready_i = 1'b0;
  logic [46:0] meta_o;
  logic [7:0] vinsn_done_i = '0;
  logic done_valid_o;
  logic [2:0] done_id_o;
  logic [7:0] busy_o;
  logic err_o;
  int checks = 0, errors = 0;
  logic [7:0] m_busy = '0;
  logic [46:0] m_meta = '0;

  vlsu_load_meta_sched dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_vl_i(req_vl_i), .req_vstart_i(req_vstart_i), .req_sew_i(req_sew_i),
    .req_vd_i(req_vd_i), .req_vm_i(req_vm_i), .req_mode_i(req_mode_i),
    .seq_meta_valid_o(seq_meta_valid_o), .seq_meta_ready_i(seq_meta_ready_i),
    .shf_meta_valid_o(shf_meta_valid_o), .shf_meta_ready_i(shf_meta_ready_i),
    .meta_o(meta_o), .vinsn_done_i(vinsn_done_i),
    .done_valid_o(done_valid_o), .done_id_o(done_id_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // one commit moves 4 lanes * 32 bytes
  function automatic logic [15:0] exp_cmt(input int vl, input int vs, input int sew);
    int b;
    b = (vl - vs) * (1 << sew);
    return 16'((b + 127) / 128 - 1);
  endfunction

  function automatic int lowest_free(input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (!b[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    vinsn_done_i = '0;
    tick();
    rst_i = 1'b0;
    m_busy = '0;
  endtask

  // offers one request until accepted (bounded); returns in the CALC cycle
  task automatic send(input int vl, input int vs, input int sew, output bit ok, output int id);
    id = lowest_free(m_busy);
    req_vl_i = 16'(vl);
    req_vstart_i = 16'(vs);
    req_sew_i = 2'(sew);
    req_vd_i = 6'($urandom);
    req_vm_i = 1'($urandom);
    req_mode_i = 3'($urandom);
    m_meta = {3'(id), req_mode_i, req_sew_i, req_vd_i, req_vstart_i, req_vm_i, (vl > vs) ? exp_cmt(vl, vs, sew) : 16'h0};
    req_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = req_ready_o;
      tick();
    end
    req_valid_i = 1'b0;
    if (ok) m_busy[id] = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    checks++; if (busy_o !== 8'h00 || err_o !== 1'b0) begin errors++; $display("FAIL reset_busy_err got=%h/%b exp=00/0", busy_o, err_o); end
    checks++; if ({seq_meta_valid_o, shf_meta_valid_o, done_valid_o} !== 3'b000) begin errors++; $display("FAIL reset_valids got=%b exp=000", {seq_meta_valid_o, shf_meta_valid_o, done_valid_o}); end
    checks++; if (meta_o !== 47'h0) begin errors++; $display("FAIL reset_meta got=%h exp=0", meta_o); end
    rst_i = 1'b0;
    m_busy = '0;
    tick();
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
  endtask

  task automatic test_issue();
    int tv[3][3] = '{'{64, 0, 2}, '{33, 0, 0}, '{129, 0, 0}};
    bit ok;
    int id;
    seq_meta_ready_i = 1'b1;
    shf_meta_ready_i = 1'b1;
    foreach (tv[n]) begin
      send(tv[n][0], tv[n][1], tv[n][2], ok, id);
      checks++; if (!ok || {seq_meta_valid_o, shf_meta_valid_o} !== 2'b00 || busy_o !== m_busy) begin errors++; $display("FAIL issue_calc ok=%b valids=%b busy=%h exp busy=%h", ok, {seq_meta_valid_o, shf_meta_valid_o}, busy_o, m_busy); end
      tick();
      checks++; if ({seq_meta_valid_o, shf_meta_valid_o} !== 2'b11 || meta_o !== m_meta) begin errors++; $display("FAIL issue_meta valids=%b meta=%h exp=11/%h", {seq_meta_valid_o, shf_meta_valid_o}, meta_o, m_meta); end
      tick();
      checks++; if ({seq_meta_valid_o, shf_meta_valid_o} !== 2'b00 || req_ready_o !== 1'b1) begin errors++; $display("FAIL issue_drop valids=%b ready=%b exp=00/1", {seq_meta_valid_o, shf_meta_valid_o}, req_ready_o); end
      vinsn_done_i = 8'(1 << id);
      tick();
      vinsn_done_i = '0;
      m_busy[id] = 1'b0;
      checks++; if (done_valid_o !== 1'b1 || done_id_o !== 3'(id) || busy_o !== m_busy) begin errors++; $display("FAIL issue_retire got=%b/%0d/%h exp=1/%0d/%h", done_valid_o, done_id_o, busy_o, id, m_busy); end
    end
  endtask

  task automatic test_zero_len();
    int tv[2][2] = '{'{8, 8}, '{3, 10}};
    bit ok;
    int id;
    foreach (tv[n]) begin
      send(tv[n][0], tv[n][1], 1, ok, id);
      checks++; if (!ok || busy_o !== m_busy || req_ready_o !== 1'b0) begin errors++; $display("FAIL zl_calc ok=%b busy=%h ready=%b exp busy=%h ready=0", ok, busy_o, req_ready_o, m_busy); end
      tick();
      m_busy[id] = 1'b0;
      checks++; if (done_valid_o !== 1'b1 || done_id_o !== 3'(id) || busy_o !== m_busy) begin errors++; $display("FAIL zl_done got=%b/%0d/%h exp=1/%0d/%h", done_valid_o, done_id_o, busy_o, id, m_busy); end
      checks++; if ({seq_meta_valid_o, shf_meta_valid_o} !== 2'b00 || req_ready_o !== 1'b1) begin errors++; $display("FAIL zl_nometa valids=%b ready=%b exp=00/1", {seq_meta_valid_o, shf_meta_valid_o}, req_ready_o); end
      tick();
      checks++; if (done_valid_o !== 1'b0 || {seq_meta_valid_o, shf_meta_valid_o} !== 2'b00) begin errors++; $display("FAIL zl_pulse done=%b valids=%b exp=0/00", done_valid_o, {seq_meta_valid_o, shf_meta_valid_o}); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int id;
    seq_meta_ready_i = 1'b1;
    shf_meta_ready_i = 1'b0;
    send(64, 0, 2, ok, id);
    tick();
    checks++; if ({seq_meta_valid_o, shf_meta_valid_o} !== 2'b11 || meta_o !== m_meta) begin errors++; $display("FAIL bp_first valids=%b meta=%h exp=11/%h", {seq_meta_valid_o, shf_meta_valid_o}, meta_o, m_meta); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({seq_meta_valid_o, shf_meta_valid_o} !== 2'b01 || meta_o !== m_meta || req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold%0d valids=%b meta=%h ready=%b exp=01/%h/0", i, {seq_meta_valid_o, shf_meta_valid_o}, meta_o, req_ready_o, m_meta); end
    end
    shf_meta_ready_i = 1'b1;
    tick();
    checks++; if ({seq_meta_valid_o, shf_meta_valid_o} !== 2'b00 || req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release valids=%b ready=%b exp=00/1", {seq_meta_valid_o, shf_meta_valid_o}, req_ready_o); end
    vinsn_done_i = 8'(1 << id);
    tick();
    vinsn_done_i = '0;
    m_busy[id] = 1'b0;
    checks++; if (busy_o !== m_busy) begin errors++; $display("FAIL bp_retire busy=%h exp=%h", busy_o, m_busy); end
  endtask

  task automatic test_pool_full();
    bit ok;
    int id;
    seq_meta_ready_i = 1'b1;
    shf_meta_ready_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      send(16 + n * 40, 0, n % 4, ok, id);
      checks++; if (!ok || busy_o !== m_busy) begin errors++; $display("FAIL full_alloc%0d ok=%b busy=%h exp=%h", n, ok, busy_o, m_busy); end
      tick();
      checks++; if (meta_o !== m_meta) begin errors++; $display("FAIL full_meta%0d got=%h exp=%h", n, meta_o, m_meta); end
      tick();
    end
    req_valid_i = 1'b1;
    tick();
    tick();
    checks++; if (req_ready_o !== 1'b0 || busy_o !== 8'hff) begin errors++; $display("FAIL full_ready ready=%b busy=%h exp=0/ff", req_ready_o, busy_o); end
    vinsn_done_i = 8'h08;
    tick();
    vinsn_done_i = '0;
    m_busy[3] = 1'b0;
    checks++; if (done_valid_o !== 1'b1 || done_id_o !== 3'd3 || busy_o !== m_busy || req_ready_o !== 1'b1) begin errors++; $display("FAIL full_retire got=%b/%0d/%h/%b exp=1/3/%h/1", done_valid_o, done_id_o, busy_o, req_ready_o, m_busy); end
    send(40, 0, 1, ok, id);
    tick();
    checks++; if (!ok || id != 3 || meta_o !== m_meta) begin errors++; $display("FAIL full_reuse ok=%b meta=%h exp=%h", ok, meta_o, m_meta); end
    do_reset();
  endtask

  task automatic test_err();
    bit ok;
    int id;
    do_reset();
    vinsn_done_i = 8'h20;
    tick();
    vinsn_done_i = '0;
    checks++; if (err_o !== 1'b1 || done_valid_o !== 1'b0 || busy_o !== 8'h00) begin errors++; $display("FAIL err_nonbusy got=%b/%b/%h exp=1/0/00", err_o, done_valid_o, busy_o); end
    tick();
    tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err_o); end
    do_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_reset got=%b exp=0", err_o); end
    seq_meta_ready_i = 1'b1;
    shf_meta_ready_i = 1'b1;
    for (int n = 0; n < 2; n++) begin
      send(64, 0, 0, ok, id);
      tick();
      tick();
    end
    vinsn_done_i = 8'h03;
    tick();
    vinsn_done_i = '0;
    checks++; if (err_o !== 1'b1 || done_valid_o !== 1'b0 || busy_o !== m_busy) begin errors++; $display("FAIL err_multi got=%b/%b/%h exp=1/0/%h", err_o, done_valid_o, busy_o, m_busy); end
    do_reset();
  endtask

  task automatic test_simultaneous();
    bit ok;
    int id;
    do_reset();
    seq_meta_ready_i = 1'b1;
    shf_meta_ready_i = 1'b1;
    send(64, 0, 0, ok, id);
    tick();
    tick();
    send(5, 9, 0, ok, id);
    vinsn_done_i = 8'h01;
    tick();
    vinsn_done_i = '0;
    m_busy[0] = 1'b0;
    checks++; if (done_valid_o !== 1'b1 || done_id_o !== 3'd0 || busy_o !== m_busy || req_ready_o !== 1'b0) begin errors++; $display("FAIL sim_retire_wins got=%b/%0d/%h/%b exp=1/0/%h/0", done_valid_o, done_id_o, busy_o, req_ready_o, m_busy); end
    tick();
    m_busy[id] = 1'b0;
    checks++; if (done_valid_o !== 1'b1 || done_id_o !== 3'(id) || busy_o !== m_busy || req_ready_o !== 1'b1) begin errors++; $display("FAIL sim_zl_held got=%b/%0d/%h/%b exp=1/%0d/%h/1", done_valid_o, done_id_o, busy_o, req_ready_o, id, m_busy); end
    send(64, 0, 0, ok, id);
    tick();
    tick();
    vinsn_done_i = 8'h01;
    send(64, 0, 0, ok, id);
    vinsn_done_i = '0;
    m_busy[0] = 1'b0;
    checks++; if (!ok || busy_o !== m_busy || done_valid_o !== 1'b1 || done_id_o !== 3'd0) begin errors++; $display("FAIL sim_alloc_retire busy=%h done=%b/%0d exp=%h/1/0", busy_o, done_valid_o, done_id_o, m_busy); end
    tick();
    checks++; if (meta_o !== m_meta) begin errors++; $display("FAIL sim_alloc_id meta=%h exp=%h", meta_o, m_meta); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int id;
    do_reset();
    seq_meta_ready_i = 1'b1;
    shf_meta_ready_i = 1'b1;
    for (int n = 0; n < 2; n++) begin
      send(64, 0, 0, ok, id);
      tick();
      tick();
    end
    seq_meta_ready_i = 1'b0;
    shf_meta_ready_i = 1'b0;
    send(64, 0, 0, ok, id);
    tick();
    checks++; if ({seq_meta_valid_o, shf_meta_valid_o} !== 2'b11 || busy_o !== 8'h07) begin errors++; $display("FAIL rmid_pre valids=%b busy=%h exp=11/07", {seq_meta_valid_o, shf_meta_valid_o}, busy_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if ({seq_meta_valid_o, shf_meta_valid_o, done_valid_o} !== 3'b000 || busy_o !== 8'h00 || meta_o !== 47'h0) begin errors++; $display("FAIL rmid_reset valids=%b busy=%h meta=%h exp=000/00/0", {seq_meta_valid_o, shf_meta_valid_o, done_valid_o}, busy_o, meta_o); end
    tick();
    rst_i = 1'b0;
    m_busy = '0;
    seq_meta_ready_i = 1'b1;
    shf_meta_ready_i = 1'b1;
    send(64, 0, 0, ok, id);
    tick();
    checks++; if (!ok || done_valid_o !== 1'b0 || busy_o !== 8'h01 || meta_o !== m_meta) begin errors++; $display("FAIL rmid_next busy=%h done=%b meta=%h exp=01/0/%h", busy_o, done_valid_o, meta_o, m_meta); end
    do_reset();
  endtask

  task automatic test_random();
    bit ok;
    int id;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if (m_busy != 8'h00 && ($urandom_range(0, 2) == 0 || m_busy == 8'hff)) begin
        int k;
        do k = $urandom_range(0, 7); while (!m_busy[k]);
        vinsn_done_i = 8'(1 << k);
        tick();
        vinsn_done_i = '0;
        m_busy[k] = 1'b0;
        checks++; if (done_valid_o !== 1'b1 || done_id_o !== 3'(k) || busy_o !== m_busy) begin errors++; $display("FAIL rnd_retire got=%b/%0d/%h exp=1/%0d/%h", done_valid_o, done_id_o, busy_o, k, m_busy); end
      end else begin
        int vl, vs, sew;
        vl = $urandom_range(0, 1) ? $urandom_range(0, 48) : $urandom_range(0, 2000);
        vs = $urandom_range(0, 40);
        sew = $urandom_range(0, 3);
        seq_meta_ready_i = 1'($urandom);
        shf_meta_ready_i = 1'($urandom);
        send(vl, vs, sew, ok, id);
        checks++; if (!ok || busy_o !== m_busy) begin errors++; $display("FAIL rnd_alloc ok=%b busy=%h exp=%h", ok, busy_o, m_busy); end
        tick();
        if (vl <= vs) begin
          m_busy[id] = 1'b0;
          checks++; if (done_valid_o !== 1'b1 || done_id_o !== 3'(id) || busy_o !== m_busy || {seq_meta_valid_o, shf_meta_valid_o} !== 2'b00) begin errors++; $display("FAIL rnd_zl got=%b/%0d/%h exp=1/%0d/%h", done_valid_o, done_id_o, busy_o, id, m_busy); end
        end else begin
          checks++; if ({seq_meta_valid_o, shf_meta_valid_o} !== 2'b11 || meta_o !== m_meta) begin errors++; $display("FAIL rnd_meta vl=%0d vs=%0d sew=%0d valids=%b meta=%h exp=%h", vl, vs, sew, {seq_meta_valid_o, shf_meta_valid_o}, meta_o, m_meta); end
          for (int c = 0; c < 40 && (seq_meta_valid_o || shf_meta_valid_o); c++) begin
            seq_meta_ready_i = 1'($urandom);
            shf_meta_ready_i = 1'($urandom);
            tick();
            if (seq_meta_valid_o || shf_meta_valid_o) begin
              checks++; if (meta_o !== m_meta) begin errors++; $display("FAIL rnd_stable meta=%h exp=%h", meta_o, m_meta); end
            end
          end
          checks++; if ({seq_meta_valid_o, shf_meta_valid_o} !== 2'b00 || req_ready_o !== (m_busy != 8'hff)) begin errors++; $display("FAIL rnd_issue_end valids=%b ready=%b exp=00/%b", {seq_meta_valid_o, shf_meta_valid_o}, req_ready_o, m_busy != 8'hff); end
        end
      end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_issue();
    test_zero_len();
    test_backpressure();
    test_pool_full();
    test_err();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
